uart_frame_timer: RTL and testbench
===================================

Name: uart_frame_timer

Overview:
- Parametrised successor to the fixed 5208-cycle baud timer and 3-bit bit counter.
- Generates bit-period ticks and tracks the position within a complete UART frame: start, data, optional parity and stop bits.
- Shared by the UART transmitter and receiver. In receiver mode the first interval is a half bit, so every later tick lands at a bit centre.
- Sits between the tx/rx FSMs and the shift registers.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD_RATE, 19200, line rate. BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE, integer divide. Elaboration error if BIT_CYCLES < 4.
- DATA_BITS, 8, data bits per frame, 5..9.
- STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame. Sampled only when busy=0.
- rxMode  in  1  sampled with start. 1 = first interval is BIT_CYCLES/2 (floor).
- clrFrame  in  1  synchronous abort back to IDLE
- busy  out  1  frame in progress
- bitTick  out  1  one-cycle pulse at the end of each bit interval
- bitPhase  out  2  0=START, 1=DATA, 2=PARITY, 3=STOP (0 when idle)
- bitIndex  out  $clog2(DATA_BITS)  data bit number (0 = LSB) during DATA, else 0
- frameDone  out  1  one-cycle pulse on the final stop-bit tick

Behaviour:
- Reset: all outputs 0, cycle counter 0, state IDLE. Reset overrides every other input.
- Priority each cycle: reset > clrFrame > normal operation.
- States: IDLE, START, DATA, PARITY, STOP.

IDLE
- busy=0; the counter is held at 0.
- start=1 -> START. busy=1 from the next cycle.
- The interval target for START is BIT_CYCLES-1, or BIT_CYCLES/2-1 if rxMode=1. rxMode is latched at this point.

Cycle counter
- Width $clog2(BIT_CYCLES).
- Counts 0..target, then wraps to 0. Every full interval after START uses target BIT_CYCLES-1.
- bitTick=1 in the cycle where counter==target. A tick therefore occurs exactly (target+1) cycles after interval entry.

Transitions on bitTick
- START -> DATA with bitIndex=0.
- DATA: bitIndex increments. On the tick with bitIndex==DATA_BITS-1, go to PARITY (if enabled) else STOP; bitIndex returns to 0.
- PARITY -> STOP.
- STOP: a stop-bit counter of 1 bit counts STOP_BITS ticks. On the last one, frameDone=1 and the state becomes IDLE the next cycle.

Timing and boundary rules
- bitPhase and bitIndex change in the cycle after bitTick and are stable for the whole interval.
- start while busy=1 is ignored. There is no queueing.
- start in the cycle frameDone=1 is ignored; the block is still busy in that cycle. Back-to-back frames need start on the first cycle with busy=0.
- clrFrame at any time, mid-interval or coincident with bitTick: next cycle state IDLE, counter 0. No bitTick or frameDone is emitted for that cycle's tick.
- clrFrame and start together in IDLE: clrFrame wins and the block stays idle.
- Frame length in cycles (rxMode=0): BIT_CYCLES*(1+DATA_BITS+P+STOP_BITS), where P=1 if parity is enabled.
- rxMode=1 shortens the frame by BIT_CYCLES - BIT_CYCLES/2.
- Tx FSMs drive the line from bitPhase/bitIndex. Rx FSMs sample the line on bitTick.

Optional Feature:
- Macro UART_PARITY_SLOT_EN.
- Defined: PARITY state present. One extra bit interval with bitPhase=2 between the last data bit and the first stop bit.
- Undefined: PARITY state and its logic are absent. DATA goes directly to STOP and bitPhase never equals 2.

Test Plan:
- Setup for all cases: CLK_FREQ_HZ=1000, BAUD_RATE=100 (BIT_CYCLES=10), DATA_BITS=8, STOP_BITS=1, no parity.
- Idle frame: pulse start with rxMode=0 -> busy rises next cycle; bitTick every 10 cycles; bitPhase sequence 0,1(x8, bitIndex 0..7),3; frameDone exactly 100 cycles after start; busy=0 the cycle after.
- Rx mode: start with rxMode=1 -> first bitTick 5 cycles after start, then every 10; frameDone at cycle 95.
- Parity + two stop bits: UART_PARITY_SLOT_EN defined, STOP_BITS=2 -> bitPhase=2 for exactly one 10-cycle interval after bitIndex 7; two STOP ticks; frameDone at cycle 120.
- Abort: clrFrame asserted on cycle 37 (during DATA, bitIndex=2), and in a second run coincident with a bitTick -> IDLE next cycle, all outputs 0, no frameDone; a new start 1 cycle later produces a clean 100-cycle frame.
- Start while busy / reset mid-frame: start pulses at cycles 20 and 99 are ignored and the frame is unchanged; reset at cycle 50 clears all outputs next cycle; start 1 cycle after reset deasserts gives a clean frame.

Source files
------------

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: bit-period tick generator and UART frame position tracker.
// Define UART_PARITY_SLOT_EN to insert a parity bit interval between data and stop bits.
module uart_frame_timer #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 19200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         rxMode,
    input  logic                         clrFrame,
    output logic                         busy,
    output logic                         bitTick,
    output logic [1:0]                   bitPhase,
    output logic [$clog2(DATA_BITS)-1:0] bitIndex,
    output logic                         frameDone
);
    localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    if (BIT_CYCLES < 4) begin : g_bit_cycles_chk
        $error("BIT_CYCLES must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_frame_chk
        $error("DATA_BITS must be 5..9 and STOP_BITS 1..2");
    end

    // Low two bits of the state code are the bitPhase value; IDLE decodes to phase 0.
    typedef enum logic [2:0] {
        START  = 3'd0,
        DATA   = 3'd1,
`ifdef UART_PARITY_SLOT_EN
        PARITY = 3'd2,
`endif
        STOP   = 3'd3,
        IDLE   = 3'd4
    } state_t;

`ifdef UART_PARITY_SLOT_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          half;
    logic          stop_cnt;
    logic          tick;

    assign busy     = (state != IDLE);
    assign bitPhase = state[1:0];

    // Ticks are gated by abort/reset so a cancelled interval never reports its end.
    always_comb begin
        tick      = (state != IDLE) && (cnt == (half ? HALF : FULL));
        bitTick   = tick && !clrFrame && !reset;
        frameDone = bitTick && (state == STOP) && (stop_cnt == LAST_STOP);
    end

    always_ff @(posedge clk) begin
        if (reset || clrFrame) begin
            state    <= IDLE;
            cnt      <= '0;
            half     <= 1'b0;
            stop_cnt <= 1'b0;
            bitIndex <= '0;
        end else if (state == IDLE) begin
            state <= start ? START : IDLE;
            half  <= rxMode;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                half <= 1'b0;
                case (state)
                    START: state <= DATA;
                    DATA: begin
                        bitIndex <= (bitIndex == LAST_IDX) ? '0 : bitIndex + 1'b1;
                        state    <= (bitIndex == LAST_IDX) ? AFTER_DATA : DATA;
                    end
`ifdef UART_PARITY_SLOT_EN
                    PARITY: state <= STOP;
`endif
                    STOP: begin
                        state    <= (stop_cnt == LAST_STOP) ? IDLE : STOP;
                        stop_cnt <= (stop_cnt == LAST_STOP) ? 1'b0 : 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_timer.sv
// tb_uart_frame_timer: table-driven frame scenarios plus random traffic on two instances
// (one and two stop bits), checked every cycle against an arithmetic frame-position model.
module tb_uart_frame_timer;
    localparam int B = 10;
    localparam int D = 8;
`ifdef UART_PARITY_SLOT_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int N0 = 1 + D + PB + 1;
    localparam int N1 = 1 + D + PB + 2;
    localparam int T = 260;

    logic clk = 1'b0;
    logic reset, start, rxMode, clrFrame;
    logic busy0, tick0, done0, busy1, tick1, done1;
    logic [1:0] phase0, phase1;
    logic [2:0] idx0, idx1;
    logic [7:0] got [2];

    always #5 clk = ~clk;

    uart_frame_timer #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .start(start), .rxMode(rxMode), .clrFrame(clrFrame),
        .busy(busy0), .bitTick(tick0), .bitPhase(phase0), .bitIndex(idx0), .frameDone(done0));
    uart_frame_timer #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(reset), .start(start), .rxMode(rxMode), .clrFrame(clrFrame),
        .busy(busy1), .bitTick(tick1), .bitPhase(phase1), .bitIndex(idx1), .frameDone(done1));

    assign got[0] = {busy0, tick0, phase0, idx0, done0};
    assign got[1] = {busy1, tick1, phase1, idx1, done1};

    int passed = 0, total = 0;
    int cur_t;
    int ticks [2];
    int last_done [2];
    logic act [2];
    int mk [2];
    logic rxl [2];

    typedef struct {
        logic rx;
        int b1, b2, clr_at, rst_at, restart;
        int dn0, dn1, tk0, tk1;
    } case_t;
    case_t cases [8];

    function automatic int flen(input int d, input logic rx);
        return B * (1 + D + PB + 1 + d) - (rx ? B - B / 2 : 0);
    endfunction

    // Position within a virtual full-length frame: every bit is B cycles, rx mode starts B-B/2 in.
    function automatic logic [7:0] model_out(input int d, input logic clr, input logic rst);
        int p, n;
        logic [1:0] ph;
        logic [2:0] ix;
        logic tk;
        if (!act[d]) return 8'h00;
        p  = mk[d] + (rxl[d] ? B - B / 2 : 0);
        n  = (p - 1) / B;
        ph = (n == 0) ? 2'd0 : (n <= D) ? 2'd1 : (PB == 1 && n == D + 1) ? 2'd2 : 2'd3;
        ix = (n >= 1 && n <= D) ? 3'(n - 1) : 3'd0;
        tk = (p % B == 0) && !clr && !rst;
        return {1'b1, tk, ph, ix, tk && (mk[d] == flen(d, rxl[d]))};
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    task automatic cyc(input logic s, input logic r, input logic c, input logic rs);
        start = s; rxMode = r; clrFrame = c; reset = rs;
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("t%0d dut%0d {busy,tick,phase,idx,done}", cur_t, d), 32'(got[d]),
                  32'(model_out(d, c, rs)));
            if (got[d][6] === 1'b1) ticks[d]++;
            if (got[d][0] === 1'b1) last_done[d] = cur_t;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rs || c) act[d] = 1'b0;
            else if (act[d]) begin
                if (mk[d] == flen(d, rxl[d])) act[d] = 1'b0;
                else mk[d]++;
            end else if (s) begin
                act[d] = 1'b1; mk[d] = 1; rxl[d] = r;
            end
        end
        cur_t++;
        #1;
    endtask

    initial begin
        cases[0] = '{1'b0, -1, -1, -1, -1, -1, 10*N0, 10*N1, N0, N1};
        cases[1] = '{1'b1, -1, -1, -1, -1, -1, 10*N0-5, 10*N1-5, N0, N1};
        cases[2] = '{1'b0, -1, -1, 37, -1, 39, 39+10*N0, 39+10*N1, 3+N0, 3+N1};
        cases[3] = '{1'b0, -1, -1, 40, -1, 42, 42+10*N0, 42+10*N1, 3+N0, 3+N1};
        cases[4] = '{1'b0, 20, 99, -1, -1, -1, 10*N0, 10*N1, N0, N1};
        cases[5] = '{1'b0, 10*N0, -1, -1, -1, 10*N0+1, 20*N0+1, 10*N1, 2*N0, N1};
        cases[6] = '{1'b0, -1, -1, -1, 50, 52, 52+10*N0, 52+10*N1, 4+N0, 4+N1};
        cases[7] = '{1'b0, -1, -1, 0, -1, -1, -1, -1, 0, 0};
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; mk[d] = 0; rxl[d] = 1'b0;
        end
        cur_t = 0;
        reset = 1'b1; start = 1'b0; rxMode = 1'b0; clrFrame = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cur_t = 0;
            for (int d = 0; d < 2; d++) begin
                ticks[d] = 0; last_done[d] = -1;
            end
            for (int t = 0; t < T; t++)
                cyc(t == 0 || t == cases[i].b1 || t == cases[i].b2 || t == cases[i].restart,
                    cases[i].rx, t == cases[i].clr_at, t == cases[i].rst_at);
            check($sformatf("case%0d dut0 frameDone cycle", i), 32'(last_done[0]), 32'(cases[i].dn0));
            check($sformatf("case%0d dut1 frameDone cycle", i), 32'(last_done[1]), 32'(cases[i].dn1));
            check($sformatf("case%0d dut0 tick count", i), 32'(ticks[0]), 32'(cases[i].tk0));
            check($sformatf("case%0d dut1 tick count", i), 32'(ticks[1]), 32'(cases[i].tk1));
        end
        cur_t = 0;
        for (int t = 0; t < 4000; t++)
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
